// File: rtl/sha256_padder.sv
// ============================================================================
// Module   : sha256_padder
// Purpose  : Byte-stream SHA-256 message padder; buffers one 64-byte block and
//            replays it to the core as a 64-cycle load/message_8 burst.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module sha256_padder #(
  parameter int LEN_W = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_last,
  input  logic       core_ready,
  output logic       out_load,
  output logic [7:0] out_byte,
  output logic       out_last_block
);

  typedef enum logic [2:0] {
    S_FILL  = 3'd0,
    S_PAD80 = 3'd1,
    S_ZERO  = 3'd2,
    S_LEN   = 3'd3,
    S_WAIT  = 3'd4,
    S_SEND  = 3'd5
  } state_t;

  state_t           r_state, w_next_state;
  state_t           r_resume, w_next_resume;
  logic [5:0]       r_idx, w_next_idx;
  logic [LEN_W-1:0] r_bitcnt, w_next_bitcnt;
  logic             r_len_pending, w_next_pending;
  logic             r_final, w_next_final;
  logic [7:0]       r_buf [64];
  logic             w_wr_en;
  logic [7:0]       w_wr_data;
  logic [63:0]      w_len64;
  logic [7:0]       w_len_byte;
  logic             r_in_ready;
  logic             r_out_load;
  logic [7:0]       r_out_byte;
  logic             r_out_last_block;

  // Length field byte for buffer index 56..63, most significant byte first.
  assign w_len64 = 64'(r_bitcnt);
  always_comb begin
    w_len_byte = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (r_idx[2:0] == 3'(k)) w_len_byte = w_len64[63-8*k -: 8];
    end
  end

  always_comb begin
    w_next_state   = r_state;
    w_next_resume  = r_resume;
    w_next_idx     = r_idx;
    w_next_bitcnt  = r_bitcnt;
    w_next_pending = r_len_pending;
    w_next_final   = r_final;
    w_wr_en        = 1'b0;
    w_wr_data      = 8'h00;
    case (r_state)
      S_FILL: begin
        if (in_valid && r_in_ready) begin
          w_wr_en       = 1'b1;
          w_wr_data     = in_data;
          w_next_idx    = r_idx + 6'd1;
          w_next_bitcnt = r_bitcnt + LEN_W'(8);
          // A full data block must be sent before its terminator can be placed.
          if (r_idx == 6'd63) begin
            w_next_state  = S_WAIT;
            w_next_final  = 1'b0;
            w_next_resume = in_last ? S_PAD80 : S_FILL;
          end else if (in_last) begin
            w_next_state = S_PAD80;
          end
        end
      end
      S_PAD80: begin
        w_wr_en    = 1'b1;
        w_wr_data  = 8'h80;
        w_next_idx = r_idx + 6'd1;
        if (r_idx == 6'd63) begin
          w_next_state  = S_WAIT;
          w_next_final  = 1'b0;
          w_next_resume = S_ZERO;
        end else if (r_idx == 6'd55) begin
          w_next_state = S_LEN;
        end else begin
          w_next_state   = S_ZERO;
          w_next_pending = (r_idx > 6'd55);
        end
      end
      S_ZERO: begin
        w_wr_en    = 1'b1;
        w_next_idx = r_idx + 6'd1;
        if (!r_len_pending && r_idx == 6'd55) begin
          w_next_state = S_LEN;
        end else if (r_len_pending && r_idx == 6'd63) begin
          w_next_state   = S_WAIT;
          w_next_final   = 1'b0;
          w_next_resume  = S_ZERO;
          w_next_pending = 1'b0;
        end
      end
      S_LEN: begin
        w_wr_en    = 1'b1;
        w_wr_data  = w_len_byte;
        w_next_idx = r_idx + 6'd1;
        if (r_idx == 6'd63) begin
          w_next_state = S_WAIT;
          w_next_final = 1'b1;
        end
      end
      S_WAIT: begin
        if (core_ready) w_next_state = S_SEND;
      end
      S_SEND: begin
        w_next_idx = r_idx + 6'd1;
        if (r_idx == 6'd63) begin
          if (r_final) begin
            w_next_state  = S_FILL;
            w_next_bitcnt = '0;
            w_next_final  = 1'b0;
          end else begin
            w_next_state = r_resume;
          end
        end
      end
      default: w_next_state = S_FILL;
    endcase
  end

  // Outputs are registered from the next-state view so they line up with SEND.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state          <= S_FILL;
      r_resume         <= S_FILL;
      r_idx            <= 6'd0;
      r_bitcnt         <= '0;
      r_len_pending    <= 1'b0;
      r_final          <= 1'b0;
      r_in_ready       <= 1'b0;
      r_out_load       <= 1'b0;
      r_out_byte       <= 8'h00;
      r_out_last_block <= 1'b0;
    end else begin
      r_state          <= w_next_state;
      r_resume         <= w_next_resume;
      r_idx            <= w_next_idx;
      r_bitcnt         <= w_next_bitcnt;
      r_len_pending    <= w_next_pending;
      r_final          <= w_next_final;
      r_in_ready       <= (w_next_state == S_FILL);
      r_out_load       <= (w_next_state == S_SEND) && (w_next_idx == 6'd0);
      r_out_byte       <= (w_next_state == S_SEND) ? r_buf[w_next_idx] : 8'h00;
      r_out_last_block <= (w_next_state == S_SEND) && w_next_final;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) r_buf[r_idx] <= w_wr_data;
  end

  assign in_ready       = r_in_ready;
  assign out_load       = r_out_load;
  assign out_byte       = r_out_byte;
  assign out_last_block = r_out_last_block;

endmodule

`default_nettype wire

// File: tb/tb_sha256_padder.sv
// ============================================================================
// Module   : tb_sha256_padder
// Purpose  : Scoreboard bench for sha256_padder; expected bursts are queued at
//            stimulus time and popped by an output monitor.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sha256_padder;

  typedef struct packed {
    logic       load;
    logic       last;
    logic [7:0] b;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic       in_last = 1'b0;
  logic       core_ready = 1'b1;
  logic       out_load;
  logic [7:0] out_byte;
  logic       out_last_block;

  exp_t       sbq [$];
  logic [7:0] msg_q [$];
  int         checks = 0;
  int         failures = 0;
  int         remain = 0;
  int         cur_idx = -1;
  int         blocks_done = 0;

  sha256_padder #(.LEN_W(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .in_last        (in_last),
    .core_ready     (core_ready),
    .out_load       (out_load),
    .out_byte       (out_byte),
    .out_last_block (out_last_block)
  );

  always #5 clk = ~clk;

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      checks++;
      if (out_load || out_byte != 8'h00 || out_last_block || in_ready) begin
        failures++;
        $display("FAIL reset_outputs: got load=%b byte=%h last=%b ready=%b required all 0",
                 out_load, out_byte, out_last_block, in_ready);
      end
      remain  = 0;
      cur_idx = -1;
      sbq.delete();
    end else if (remain > 0 || out_load) begin
      if (remain == 0) remain = 64;
      cur_idx = 64 - remain;
      checks++;
      if (sbq.size() == 0) begin
        failures++;
        $display("FAIL unexpected_output: got load=%b byte=%h with no expected data",
                 out_load, out_byte);
      end else begin
        e = sbq.pop_front();
        if (out_load !== e.load || out_last_block !== e.last || out_byte !== e.b) begin
          failures++;
          $display("FAIL burst_byte[%0d]: got load=%b last=%b byte=%h required load=%b last=%b byte=%h",
                   cur_idx, out_load, out_last_block, out_byte, e.load, e.last, e.b);
        end
      end
      remain--;
      if (remain == 0) blocks_done++;
    end else begin
      cur_idx = -1;
      checks++;
      if (out_byte != 8'h00 || out_last_block) begin
        failures++;
        $display("FAIL idle_outputs: got byte=%h last=%b required 00/0", out_byte, out_last_block);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, got, req);
    end
  endtask

  // Reference padding of msg_q, pushed as expected burst entries.
  task automatic push_expected();
    logic [7:0]  pad [$];
    logic [63:0] bits;
    int          n;
    pad  = msg_q;
    bits = 64'(msg_q.size()) * 64'd8;
    pad.push_back(8'h80);
    while (pad.size() % 64 != 56) pad.push_back(8'h00);
    for (int k = 7; k >= 0; k--) pad.push_back(bits[8*k +: 8]);
    n = pad.size();
    for (int k = 0; k < n; k++) begin
      exp_t e;
      e.load = (k % 64 == 0);
      e.last = (k >= n - 64);
      e.b    = pad[k];
      sbq.push_back(e);
    end
  endtask

  task automatic drive_msg(input bit gap);
    int n;
    for (int i = 0; i < msg_q.size(); i++) begin
      in_valid = 1'b1;
      in_data  = msg_q[i];
      in_last  = (i == msg_q.size() - 1);
      n = 0;
      while (!in_ready && n < 2000) begin
        @(negedge clk); #1;
        n++;
      end
      if (n >= 2000) begin
        check("handshake_timeout", 32'd1, 32'd0);
        in_valid = 1'b0;
        return;
      end
      @(negedge clk); #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      if (gap) begin
        @(negedge clk); #1;
      end
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((sbq.size() != 0 || remain != 0) && n < 3000) begin
      @(negedge clk); #1;
      n++;
    end
    check(name, 32'(sbq.size() + remain), 32'd0);
  endtask

  task automatic load_abc();
    msg_q.delete();
    msg_q.push_back(8'h61);
    msg_q.push_back(8'h62);
    msg_q.push_back(8'h63);
  endtask

  task automatic load_seq(input int len);
    msg_q.delete();
    for (int i = 0; i < len; i++) msg_q.push_back(8'(i * 3 + 1));
  endtask

  initial begin
    int  target;
    int  n;
    bit  bad;

    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk); #1;
    check("ready_after_reset", 32'(in_ready), 32'd1);

    // "abc": one final block ending in length 0x18.
    load_abc();
    push_expected();
    drive_msg(1'b0);
    wait_idle("abc_drain");

    // 55 bytes: terminator at 55, single block.
    load_seq(55);
    push_expected();
    drive_msg(1'b0);
    wait_idle("len55_drain");

    // 56 bytes: terminator spills the length into a second block.
    load_seq(56);
    push_expected();
    drive_msg(1'b0);
    wait_idle("len56_drain");

    // 64 bytes with gapped valid: full data block then a padding-only block.
    load_seq(64);
    push_expected();
    target = blocks_done + 2;
    drive_msg(1'b1);
    bad = 1'b0;
    n   = 0;
    while (n < 2000) begin
      if (in_ready) bad = 1'b1;
      if (blocks_done >= target) break;
      @(negedge clk); #1;
      n++;
    end
    check("len64_ready_low", 32'(bad), 32'd0);
    check("len64_blocks", 32'(blocks_done), 32'(target));
    @(negedge clk); #1;
    check("len64_ready_back", 32'(in_ready), 32'd1);
    wait_idle("len64_drain");

    // core_ready held low: padded block must wait in WAIT.
    core_ready = 1'b0;
    load_abc();
    push_expected();
    drive_msg(1'b0);
    bad = 1'b0;
    repeat (100) begin
      @(negedge clk); #1;
      if (out_load) bad = 1'b1;
    end
    check("hold_no_load", 32'(bad), 32'd0);
    core_ready = 1'b1;
    @(negedge clk); #1;
    check("hold_release_load", 32'(out_load), 32'd1);
    wait_idle("hold_drain");

    // Reset in the middle of a burst at index 20.
    load_abc();
    push_expected();
    drive_msg(1'b0);
    n = 0;
    while (!(remain > 0 && cur_idx == 20) && n < 2000) begin
      @(negedge clk); #1;
      n++;
    end
    check("reach_send_idx20", 32'(cur_idx), 32'd20);
    rst = 1'b0;
    @(negedge clk); #1;
    rst = 1'b1;
    @(negedge clk); #1;
    check("ready_after_midsend_reset", 32'(in_ready), 32'd1);
    check("queue_flushed", 32'(sbq.size()), 32'd0);

    load_abc();
    push_expected();
    drive_msg(1'b0);
    wait_idle("abc_after_reset_drain");

    repeat (5) @(negedge clk);
    #1;
    check("final_queue_empty", 32'(sbq.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
